// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the switch-box configuration loader: FSM encoding,
// code/checksum widths, the highest defined switch mode and checksum helpers.
package sb_cfg_pkg;

    localparam int SB_SW_W = 5;
    localparam int CSUM_W = 8;
    localparam logic [4:0] SB_MAX_CODE = 5'b00011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERROR  = 3'd4
    } sb_state_e;

    // Fold one zero-extended switch code into the running XOR checksum.
    function automatic logic [CSUM_W-1:0] csum_fold(
        input logic [CSUM_W-1:0] acc,
        input logic [CSUM_W-1:0] code
    );
        return acc ^ code;
    endfunction

    // A code is legal when it names one of the defined switch modes.
    function automatic logic code_legal(input logic [CSUM_W-1:0] code);
        return (code <= CSUM_W'(SB_MAX_CODE));
    endfunction

endpackage

// File: rtl/sb_cfg_checker.sv
// Combinational frame check over the shadow codes: XOR checksum of all
// zero-extended codes must match the received byte and every code must be a
// defined switch mode. Codes are assumed no wider than the checksum.
module sb_cfg_checker
    import sb_cfg_pkg::*;
#(
    parameter int N_SB = 8,
    parameter int SW_W = SB_SW_W
) (
    input  logic [N_SB*SW_W-1:0] codes,
    input  logic [CSUM_W-1:0]    csum_rx,
    output logic                 check_ok
);

    logic [CSUM_W-1:0] csum_calc_s;
    logic              range_ok_s;
    logic [CSUM_W-1:0] code_ext_s;

    // Accumulate the checksum and the range verdict across all boxes.
    always_comb begin
        csum_calc_s = '0;
        range_ok_s  = 1'b1;
        code_ext_s  = '0;
        for (int k = 0; k < N_SB; k++) begin
            code_ext_s  = CSUM_W'(codes[k*SW_W +: SW_W]);
            csum_calc_s = csum_fold(csum_calc_s, code_ext_s);
            if (!code_legal(code_ext_s)) begin
                range_ok_s = 1'b0;
            end else begin
                range_ok_s = range_ok_s;
            end
        end
        check_ok = range_ok_s && (csum_calc_s == csum_rx);
    end

endmodule

// File: rtl/sb_config_loader.sv
// Serial configuration loader for N_SB switch boxes. A frame is shifted into
// a shadow register, checked, and only then committed atomically to the
// interconnect_switch outputs; CLB_prgm_b stays low unless a checked
// configuration is in force.
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int N_SB = 8,
    parameter int SW_W = SB_SW_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prgm_b,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [N_SB*SW_W-1:0] interconnect_switch,
    output logic                 CLB_prgm_b,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int DATA_W    = N_SB * SW_W;
    localparam int FRAME_LEN = DATA_W + CSUM_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    sb_state_e             state_r;
    sb_state_e             state_nxt_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [FRAME_LEN-1:0]  shadow_r;
    logic                  armed_r;
    logic                  clb_saved_r;
    logic                  cfg_ready_r;
    logic [DATA_W-1:0]     switch_r;
    logic                  clb_prgm_b_r;
    logic                  cfg_done_r;
    logic                  cfg_err_r;

    logic                  last_bit_s;
    logic                  check_ok_s;
    logic [DATA_W-1:0]     codes_s;
    logic [CSUM_W-1:0]     csum_s;
    logic                  start_s;
    logic                  abort_s;
    logic                  accept_s;
    logic                  commit_s;
    logic                  fail_s;
    logic                  clb_set_s;

    // Shadow holds box 0 in its top bits (first bit in ends up at the MSB);
    // re-pack so box k sits at [k*SW_W +: SW_W] like the output bus.
    for (genvar k = 0; k < N_SB; k++) begin : g_unpack
        assign codes_s[k*SW_W +: SW_W] = shadow_r[FRAME_LEN-1-k*SW_W -: SW_W];
    end
    assign csum_s     = shadow_r[CSUM_W-1:0];
    assign last_bit_s = (bit_cnt_r == CNT_W'(FRAME_LEN - 1));

    sb_cfg_checker #(
        .N_SB (N_SB),
        .SW_W (SW_W)
    ) u_checker (
        .codes    (codes_s),
        .csum_rx  (csum_s),
        .check_ok (check_ok_s)
    );

    // State register; reset overrides any transition in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!prgm_b && armed_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (prgm_b) begin
                    state_nxt_s = ST_IDLE;
                end else if (cfg_valid && cfg_ready_r && last_bit_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (check_ok_s) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            ST_ERROR: begin
                if (prgm_b) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath registers.
    always_comb begin
        start_s   = 1'b0;
        abort_s   = 1'b0;
        accept_s  = 1'b0;
        commit_s  = 1'b0;
        fail_s    = 1'b0;
        clb_set_s = 1'b0;
        case (state_r)
            ST_IDLE:   start_s = !prgm_b && armed_r;
            ST_LOAD: begin
                abort_s  = prgm_b;
                accept_s = !prgm_b && cfg_valid && cfg_ready_r;
            end
            ST_CHECK: begin
                commit_s = check_ok_s;
                fail_s   = !check_ok_s;
            end
            ST_COMMIT: clb_set_s = 1'b1;
            ST_ERROR:  clb_set_s = 1'b0;
            default:   clb_set_s = 1'b0;
        endcase
    end

    // Datapath and registered outputs. armed_r makes frame start
    // edge-qualified: it is re-armed only by seeing prgm_b high.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r    <= '0;
            shadow_r     <= '0;
            armed_r      <= 1'b1;
            clb_saved_r  <= 1'b0;
            cfg_ready_r  <= 1'b0;
            switch_r     <= '0;
            clb_prgm_b_r <= 1'b0;
            cfg_done_r   <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            cfg_ready_r <= (state_nxt_s == ST_LOAD);
            cfg_done_r  <= commit_s;

            if (prgm_b) begin
                armed_r <= 1'b1;
            end else if (start_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end

            if (start_s) begin
                bit_cnt_r <= '0;
                shadow_r  <= '0;
            end else if (accept_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                shadow_r  <= {shadow_r[FRAME_LEN-2:0], cfg_bit};
            end else begin
                bit_cnt_r <= bit_cnt_r;
                shadow_r  <= shadow_r;
            end

            if (commit_s) begin
                switch_r <= codes_s;
            end else begin
                switch_r <= switch_r;
            end

            if (start_s) begin
                cfg_err_r <= 1'b0;
            end else if (fail_s) begin
                cfg_err_r <= 1'b1;
            end else begin
                cfg_err_r <= cfg_err_r;
            end

            if (start_s) begin
                clb_saved_r  <= clb_prgm_b_r;
                clb_prgm_b_r <= 1'b0;
            end else if (abort_s) begin
                clb_saved_r  <= clb_saved_r;
                clb_prgm_b_r <= clb_saved_r;
            end else if (clb_set_s) begin
                clb_saved_r  <= clb_saved_r;
                clb_prgm_b_r <= 1'b1;
            end else begin
                clb_saved_r  <= clb_saved_r;
                clb_prgm_b_r <= clb_prgm_b_r;
            end
        end
    end

    assign cfg_ready           = cfg_ready_r;
    assign interconnect_switch = switch_r;
    assign CLB_prgm_b          = clb_prgm_b_r;
    assign cfg_done            = cfg_done_r;
    assign cfg_err             = cfg_err_r;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader with two switch boxes (18-bit frames).
module tb_sb_config_loader;

    localparam int N_SB = 2;
    localparam int SW_W = 5;
    localparam int DW   = N_SB * SW_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          prgm_b;
    logic          cfg_bit;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] interconnect_switch;
    logic          CLB_prgm_b;
    logic          cfg_done;
    logic          cfg_err;

    int errors = 0;
    int checks = 0;

    // Frames: {box0, box1, checksum}, sent MSB first.
    logic [17:0] f_good1 = {5'b00001, 5'b00010, 8'h03};
    logic [17:0] f_badcs = {5'b00001, 5'b00010, 8'h07};
    logic [17:0] f_range = {5'b00001, 5'b00100, 8'h05};
    logic [17:0] f_good2 = {5'b00011, 5'b00000, 8'h03};
    logic [17:0] f_good3 = {5'b00010, 5'b00011, 8'h01};

    sb_config_loader #(
        .N_SB (N_SB),
        .SW_W (SW_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .prgm_b              (prgm_b),
        .cfg_bit             (cfg_bit),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .interconnect_switch (interconnect_switch),
        .CLB_prgm_b          (CLB_prgm_b),
        .cfg_done            (cfg_done),
        .cfg_err             (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send frame bits [17-first] downward; toggle inserts an invalid cycle
    // (carrying the wrong bit) before every valid one.
    task automatic send_bits(input logic [17:0] frame, input int first, input int count,
                             input bit toggle);
        for (int i = first; i < first + count; i++) begin
            if (toggle) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~frame[17-i];
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit   = frame[17-i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic new_frame();
        prgm_b = 1'b1;
        tick();
        prgm_b = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        prgm_b    = 1'b1;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        check_eq("rst_switch", 32'(interconnect_switch), 32'h0);
        check_eq("rst_clb",    32'(CLB_prgm_b), 32'd0);
        check_eq("rst_ready",  32'(cfg_ready),  32'd0);
        check_eq("rst_done",   32'(cfg_done),   32'd0);
        check_eq("rst_err",    32'(cfg_err),    32'd0);
        reset = 1'b0;
        tick();

        // Good frame commits.
        prgm_b = 1'b0;
        tick();
        check_eq("g1_ready_load", 32'(cfg_ready), 32'd1);
        check_eq("g1_clb_load",   32'(CLB_prgm_b), 32'd0);
        send_bits(f_good1, 0, 18, 1'b0);
        check_eq("g1_ready_check", 32'(cfg_ready), 32'd0);
        check_eq("g1_done_early",  32'(cfg_done),  32'd0);
        tick();
        check_eq("g1_done",   32'(cfg_done), 32'd1);
        check_eq("g1_switch", 32'(interconnect_switch), 32'h041);
        check_eq("g1_clb_commit", 32'(CLB_prgm_b), 32'd0);
        tick();
        check_eq("g1_done_pulse", 32'(cfg_done), 32'd0);
        check_eq("g1_clb", 32'(CLB_prgm_b), 32'd1);

        // prgm_b held low after commit must not restart a frame.
        tick();
        tick();
        tick();
        check_eq("hold_low_ready", 32'(cfg_ready), 32'd0);
        check_eq("hold_low_clb",   32'(CLB_prgm_b), 32'd1);

        // Checksum error.
        new_frame();
        check_eq("cs_ready", 32'(cfg_ready), 32'd1);
        send_bits(f_badcs, 0, 18, 1'b0);
        tick();
        check_eq("cs_err",    32'(cfg_err), 32'd1);
        check_eq("cs_done",   32'(cfg_done), 32'd0);
        check_eq("cs_switch", 32'(interconnect_switch), 32'h041);
        check_eq("cs_clb",    32'(CLB_prgm_b), 32'd0);
        tick();
        tick();
        check_eq("err_stay_ready", 32'(cfg_ready), 32'd0);
        prgm_b = 1'b1;
        tick();
        check_eq("err_sticky", 32'(cfg_err), 32'd1);
        check_eq("err_clb",    32'(CLB_prgm_b), 32'd0);

        // Illegal code with matching checksum.
        prgm_b = 1'b0;
        tick();
        check_eq("rg_err_clear", 32'(cfg_err), 32'd0);
        send_bits(f_range, 0, 18, 1'b0);
        tick();
        check_eq("rg_err",    32'(cfg_err), 32'd1);
        check_eq("rg_done",   32'(cfg_done), 32'd0);
        check_eq("rg_switch", 32'(interconnect_switch), 32'h041);
        tick();
        check_eq("rg_no_commit", 32'(interconnect_switch), 32'h041);

        // Good frame after errors.
        new_frame();
        send_bits(f_good2, 0, 18, 1'b0);
        tick();
        check_eq("g2_done",   32'(cfg_done), 32'd1);
        check_eq("g2_switch", 32'(interconnect_switch), 32'h003);
        tick();
        check_eq("g2_clb", 32'(CLB_prgm_b), 32'd1);

        // Abort after 6 bits.
        new_frame();
        check_eq("ab_clb_load", 32'(CLB_prgm_b), 32'd0);
        send_bits(f_good1, 0, 6, 1'b0);
        prgm_b = 1'b1;
        tick();
        check_eq("ab_ready",  32'(cfg_ready), 32'd0);
        check_eq("ab_err",    32'(cfg_err), 32'd0);
        check_eq("ab_clb",    32'(CLB_prgm_b), 32'd1);
        check_eq("ab_switch", 32'(interconnect_switch), 32'h003);
        tick();
        check_eq("ab_done", 32'(cfg_done), 32'd0);
        prgm_b = 1'b0;
        tick();
        send_bits(f_good1, 0, 18, 1'b0);
        tick();
        check_eq("ab_next_done",   32'(cfg_done), 32'd1);
        check_eq("ab_next_switch", 32'(interconnect_switch), 32'h041);
        tick();

        // cfg_valid toggling every cycle.
        new_frame();
        send_bits(f_good3, 0, 17, 1'b1);
        check_eq("tg_ready_17", 32'(cfg_ready), 32'd1);
        send_bits(f_good3, 17, 1, 1'b1);
        check_eq("tg_ready_18", 32'(cfg_ready), 32'd0);
        tick();
        check_eq("tg_done",   32'(cfg_done), 32'd1);
        check_eq("tg_switch", 32'(interconnect_switch), 32'h062);
        tick();
        check_eq("tg_clb", 32'(CLB_prgm_b), 32'd1);

        // Reset mid-frame at bit 9.
        new_frame();
        send_bits(f_good1, 0, 9, 1'b0);
        reset = 1'b1;
        tick();
        check_eq("mr_switch", 32'(interconnect_switch), 32'h0);
        check_eq("mr_clb",    32'(CLB_prgm_b), 32'd0);
        check_eq("mr_ready",  32'(cfg_ready), 32'd0);
        check_eq("mr_done",   32'(cfg_done), 32'd0);
        check_eq("mr_err",    32'(cfg_err), 32'd0);
        reset  = 1'b0;
        prgm_b = 1'b1;
        tick();
        check_eq("mr_idle_ready", 32'(cfg_ready), 32'd0);
        prgm_b = 1'b0;
        tick();
        check_eq("mr_restart_ready", 32'(cfg_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_config_loader.md
SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

Interface
REQ-001 SHALL have parameter N_SB, default 8: number of switch-box units driven.
REQ-002 SHALL have parameter SW_W, default 5: width of one interconnect_switch code.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port prgm_b, input, 1: active-low program enable; low requests a configuration frame.
REQ-006 SHALL have port cfg_bit, input, 1: serial configuration data.
REQ-007 SHALL have port cfg_valid, input, 1: cfg_bit valid this cycle.
REQ-008 SHALL have port cfg_ready, output, 1: loader accepts a bit this cycle.
REQ-009 SHALL have port interconnect_switch, output, N_SB*SW_W: committed codes, box k at bits [k*SW_W +: SW_W].
REQ-010 SHALL have port CLB_prgm_b, output, 1: active-low; high only while a committed, valid configuration is applied.
REQ-011 SHALL have port cfg_done, output, 1: one-cycle pulse on successful commit.
REQ-012 SHALL have port cfg_err, output, 1: sticky error flag, cleared on next frame start.

Function
REQ-013 SHALL implement states IDLE, LOAD, CHECK, COMMIT, ERROR.
REQ-014 Frame SHALL be N_SB*SW_W data bits (box 0 first, each code MSB first), then an 8-bit checksum (MSB first); total FRAME_LEN = N_SB*SW_W+8.
REQ-015 A bit SHALL be accepted only on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready=1 only in LOAD.
REQ-016 IDLE->LOAD SHALL occur on the cycle prgm_b is sampled low; bit counter and shadow register cleared; cfg_err cleared; CLB_prgm_b driven low.
REQ-017 LOAD SHALL shift accepted bits into a shadow register and increment a counter; at the accept of bit FRAME_LEN-1, next state CHECK.
REQ-018 CHECK (one cycle) SHALL compare received checksum to XOR of all N_SB codes zero-extended to 8 bits, and check every code <= 5'b00011 (defined switch modes).
REQ-019 Check pass SHALL go to COMMIT: shadow copied to interconnect_switch in that cycle, cfg_done pulsed, CLB_prgm_b high from next cycle, then IDLE.
REQ-020 Check fail SHALL go to ERROR: cfg_err set, interconnect_switch unchanged, CLB_prgm_b held low.
REQ-021 ERROR SHALL remain until prgm_b sampled high, then IDLE; a new frame requires prgm_b low again.
REQ-022 prgm_b sampled high during LOAD SHALL abort: shadow discarded, next state IDLE, interconnect_switch unchanged, CLB_prgm_b restored to its pre-frame value, cfg_err not set.
REQ-023 While in IDLE with prgm_b held low after a commit, no new frame SHALL start until prgm_b returns high and falls again (edge-qualified).
REQ-024 cfg_valid=0 gaps in LOAD SHALL stall the counter indefinitely with no timeout.
REQ-025 interconnect_switch SHALL change only in COMMIT; never partially.

Reset
REQ-026 reset SHALL force: state IDLE, counter 0, shadow 0, interconnect_switch all 0, CLB_prgm_b 0, cfg_ready 0, cfg_done 0, cfg_err 0.
REQ-027 reset asserted mid-frame SHALL take priority over all transitions that cycle.

Structure
REQ-028 State encoding, SW_W, checksum width 8 and max legal code 5'b00011 SHALL live in a shared package (sb_cfg_pkg).
REQ-029 One sub-module, sb_cfg_checker (combinational XOR checksum plus code-range check over the shadow register), SHALL be instantiated.

Verification
REQ-030 N_SB=2: prgm_b low, bits 00001,00010, checksum 0x03 -> cfg_done pulse, interconnect_switch=10'b00010_00001, CLB_prgm_b=1.
REQ-031 Same frame, checksum 0x07 -> cfg_err=1, interconnect_switch keeps prior value, CLB_prgm_b=0 until next good frame.
REQ-032 Code 5'b00100 in box 1 with matching checksum 0x05 -> cfg_err=1, no commit.
REQ-033 prgm_b high after 6 bits -> return to IDLE, cfg_err=0, outputs unchanged; next full good frame commits.
REQ-034 cfg_valid toggling 1/0 every cycle over a full frame -> commit after exactly 18 accepted bits.
REQ-035 reset asserted at bit 9 -> all outputs 0 next cycle, state IDLE.
